// File: rtl/fifo_stream_pkg.sv
// Shared sizing helpers for the FIFO read-side stream adapter.
package fifo_stream_pkg;

    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int inflight_width(input int rd_latency);
        return $clog2(rd_latency + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_skid.sv
// Circular skid buffer: DEPTH entries with push at the tail, pop at the head and an occupancy count.
module fifo_rd_stream_skid
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int OCC_W = 2
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Push,
    input  logic [WIDTH-1:0] i_Push_Data,
    input  logic             i_Pop,
    output logic             o_Valid,
    output logic [WIDTH-1:0] o_Data,
    output logic [OCC_W-1:0] o_Occ
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        if (i_Push) begin
            mem_d[tail_q] = i_Push_Data;
            tail_d        = next_ptr(tail_q);
        end else begin
            tail_d = tail_q;
        end
        if (i_Pop) begin
            head_d = next_ptr(head_q);
        end else begin
            head_d = head_q;
        end
        case ({i_Push, i_Pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

`ifndef SYNTHESIS
    // A capture into a full buffer without a simultaneous pop means the credit logic is broken.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst && i_Push && !i_Pop && (occ_q == OCC_W'(DEPTH))) begin
            $error("fifo_rd_stream_skid: write into full buffer");
        end
    end
`endif

    assign o_Valid = (occ_q != '0);
    assign o_Data  = mem_q[head_q];
    assign o_Occ   = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter turning a fixed-latency FIFO read port into a valid/ready stream.
// Optional packet framing (o_Tx_Last, i_Pkt_Len) is built when FIFO_RD_STREAM_LAST_EN is defined.
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int RD_LATENCY = 2
`ifdef FIFO_RD_STREAM_LAST_EN
    ,
    parameter int LEN_W      = 16
`endif
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    output logic             o_Rd_En,
    input  logic             i_Empty,
    input  logic [WIDTH-1:0] i_Rd_Data,
    output logic             o_Tx_DV,
    output logic [WIDTH-1:0] o_Tx_Data,
    input  logic             i_Tx_Ready,
    output logic             o_Busy
`ifdef FIFO_RD_STREAM_LAST_EN
    ,
    input  logic [LEN_W-1:0] i_Pkt_Len,
    output logic             o_Tx_Last
`endif
);

    localparam int DEPTH = buf_depth(RD_LATENCY);
    localparam int OCC_W = occ_width(DEPTH);
    localparam int FL_W  = inflight_width(RD_LATENCY);
    localparam int SUM_W = OCC_W + 1;

    logic [RD_LATENCY-1:0] sr_q, sr_d;
    logic [FL_W-1:0]       inflight_s;
    logic [OCC_W-1:0]      occ_s;
    logic [SUM_W-1:0]      credit_s;
    logic                  pop_s;
    logic                  rd_en_s;

    fifo_rd_stream_skid #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_skid (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Push      (sr_q[RD_LATENCY-1]),
        .i_Push_Data (i_Rd_Data),
        .i_Pop       (pop_s),
        .o_Valid     (o_Tx_DV),
        .o_Data      (o_Tx_Data),
        .o_Occ       (occ_s)
    );

    // Credit counts the same-cycle pop so throughput resumes without a bubble after a stall.
    always_comb begin
        pop_s      = o_Tx_DV & i_Tx_Ready;
        inflight_s = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_s = inflight_s + FL_W'(sr_q[i]);
        end
        credit_s = SUM_W'(occ_s) + SUM_W'(inflight_s) - SUM_W'(pop_s);
        rd_en_s  = ~i_Empty & (credit_s < SUM_W'(DEPTH));
        sr_d     = sr_q << 1;
        sr_d[0]  = rd_en_s;
    end

    // In-flight read tracking.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign o_Rd_En = rd_en_s;
    assign o_Busy  = (occ_s != '0) | (sr_q != '0);

`ifdef FIFO_RD_STREAM_LAST_EN
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] eff_len_s;
    logic             last_s;

    // At a packet start the live length applies; later beats use the latched copy.
    always_comb begin
        eff_len_s = (beat_q == '0) ? i_Pkt_Len : len_q;
        last_s    = o_Tx_DV & (eff_len_s != '0) & (beat_q == eff_len_s - LEN_W'(1));
        if (pop_s) begin
            if (beat_q == '0) begin
                len_d = i_Pkt_Len;
            end else begin
                len_d = len_q;
            end
            if (last_s || (eff_len_s == '0)) begin
                beat_d = '0;
            end else begin
                beat_d = beat_q + LEN_W'(1);
            end
        end else begin
            len_d  = len_q;
            beat_d = beat_q;
        end
    end

    // Packet beat counter and latched length.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            beat_q <= '0;
            len_q  <= '0;
        end else begin
            beat_q <= beat_d;
            len_q  <= len_d;
        end
    end

    assign o_Tx_Last = last_s;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based FIFO and buffer model plus directed scenarios.
module tb_fifo_rd_stream;

    localparam int WIDTH = 8;
    localparam int L     = 2;
    localparam int DEPTH = L + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             rd_en;
    logic             empty;
    logic [WIDTH-1:0] rd_data;
    logic             tx_dv;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             busy;
`ifdef FIFO_RD_STREAM_LAST_EN
    logic [15:0]      pkt_len;
    logic             tx_last;
`endif

    fifo_rd_stream #(
        .WIDTH      (WIDTH),
        .RD_LATENCY (L)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .o_Rd_En    (rd_en),
        .i_Empty    (empty),
        .i_Rd_Data  (rd_data),
        .o_Tx_DV    (tx_dv),
        .o_Tx_Data  (tx_data),
        .i_Tx_Ready (tx_ready),
        .o_Busy     (busy)
`ifdef FIFO_RD_STREAM_LAST_EN
        ,
        .i_Pkt_Len  (pkt_len),
        .o_Tx_Last  (tx_last)
`endif
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_err    = 0;
    int               cyc      = 0;
    logic [7:0]       fifo_q[$];
    logic [7:0]       exp_stream[$];
    logic [7:0]       buf_m[$];
    logic             pipe_v[L];
    logic [7:0]       pipe_d[L];
    logic [7:0]       log_d[$];
    int               log_c[$];
    logic             log_l[$];
    int               rd_cnt;
    int               first_rd;
    int               first_dv;
    logic             prev_stall;
    logic [7:0]       prev_data;
    logic             rand_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int inflight_m();
        int n = 0;
        for (int i = 0; i < L; i++) begin
            if (pipe_v[i]) n++;
        end
        return n;
    endfunction

    function automatic logic busy_m();
        return (buf_m.size() != 0) || (inflight_m() != 0);
    endfunction

    // One clock: check outputs at the falling edge, then advance the FIFO and buffer models.
    task automatic cycle();
        int   infl;
        logic m_pop;
        logic m_rd;
        logic s_rd;
        @(negedge clk);
        infl  = inflight_m();
        m_pop = (buf_m.size() != 0) && tx_ready;
        m_rd  = !empty && ((buf_m.size() + infl - int'(m_pop)) < DEPTH);
        check("tx_dv", 32'(tx_dv), 32'(buf_m.size() != 0));
        if (buf_m.size() != 0) check("tx_data", 32'(tx_data), 32'(buf_m[0]));
        check("busy", 32'(busy), 32'(busy_m()));
        check("rd_en", 32'(rd_en), 32'(m_rd));
        if (prev_stall) begin
            check("hold_dv", 32'(tx_dv), 32'(1'b1));
            check("hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (m_pop) begin
            if (exp_stream.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL stream_dup: got %0h expected no word (cycle %0d)", tx_data, cyc);
            end else begin
                check("stream_order", 32'(tx_data), 32'(exp_stream.pop_front()));
            end
            log_d.push_back(tx_data);
            log_c.push_back(cyc);
`ifdef FIFO_RD_STREAM_LAST_EN
            log_l.push_back(tx_last);
`endif
        end
        if (rd_en) rd_cnt++;
        if (rd_en && first_rd < 0) first_rd = cyc;
        if (tx_dv && first_dv < 0) first_dv = cyc;
        prev_stall = tx_dv && !tx_ready;
        prev_data  = tx_data;
        s_rd       = rd_en;
        @(posedge clk);
        #1;
        cyc++;
        if (m_pop) void'(buf_m.pop_front());
        if (pipe_v[L-1]) buf_m.push_back(pipe_d[L-1]);
        for (int i = L - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        pipe_v[0] = s_rd && (fifo_q.size() != 0);
        pipe_d[0] = pipe_v[0] ? fifo_q.pop_front() : 8'h00;
        empty     = (fifo_q.size() == 0);
        rd_data   = pipe_v[L-1] ? pipe_d[L-1] : 8'h00;
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic load(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_stream.push_back(w);
        empty = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_stream.size() != 0 || busy_m()) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_left", 32'(exp_stream.size()), 32'd0);
    endtask

    task automatic clear_log();
        log_d.delete();
        log_c.delete();
        log_l.delete();
    endtask

    // Reset also clears the FIFO, which shares the reset.
    task automatic do_reset();
        rst = 1'b1;
        fifo_q.delete();
        exp_stream.delete();
        buf_m.delete();
        for (int i = 0; i < L; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = 8'h00;
        end
        empty      = 1'b1;
        rd_data    = 8'h00;
        tx_ready   = 1'b0;
        rand_ready = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        check("rst_dv", 32'(tx_dv), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
`ifdef FIFO_RD_STREAM_LAST_EN
        check("rst_last", 32'(tx_last), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
`ifdef FIFO_RD_STREAM_LAST_EN
        pkt_len = 16'd0;
`endif
        do_reset();

        // Basic stream: 0x11..0x18 with ready held high.
        tx_ready = 1'b1;
        first_rd = -1;
        first_dv = -1;
        clear_log();
        for (int i = 0; i < 8; i++) load(8'h11 + 8'(i));
        drain(100);
        check("t1_count", 32'(log_d.size()), 32'd8);
        for (int i = 0; i < log_d.size(); i++) begin
            check("t1_data", 32'(log_d[i]), 32'(8'h11 + 8'(i)));
            check("t1_b2b", 32'(log_c[i] - log_c[0]), 32'(i));
        end
        // rd_en is registered by the edge ending its cycle; data is captured L edges later.
        check("t1_latency", 32'(first_dv - first_rd), 32'(L + 1));

        // Stall: 10 words, ready low for 20 cycles.
        do_reset();
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) load(8'h30 + 8'(i));
        repeat (20) cycle();
        check("t2_stall_reads", 32'(rd_cnt), 32'(DEPTH));
        check("t2_held_dv", 32'(tx_dv), 32'd1);
        check("t2_held_data", 32'(tx_data), 32'h30);
        tx_ready = 1'b1;
        clear_log();
        drain(100);
        check("t2_count", 32'(log_d.size()), 32'd10);
        for (int i = 0; i < log_d.size(); i++) begin
            check("t2_data", 32'(log_d[i]), 32'(8'h30 + 8'(i)));
            check("t2_b2b", 32'(log_c[i] - log_c[0]), 32'(i));
        end

        // Random ready over 1000 random words.
        do_reset();
        clear_log();
        rand_ready = 1'b1;
        tx_ready   = 1'b1;
        for (int i = 0; i < 1000; i++) load(8'($urandom));
        drain(6000);
        rand_ready = 1'b0;
        check("t3_count", 32'(log_d.size()), 32'd1000);

        // Reset with reads in flight and words buffered.
        do_reset();
        for (int i = 0; i < 10; i++) load(8'h50 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            if (buf_m.size() >= 2 && inflight_m() >= 1) break;
            cycle();
        end
        check("t4_pre_buffered", 32'(buf_m.size()), 32'd2);
        check("t4_pre_busy", 32'(busy), 32'd1);
        do_reset();
        clear_log();
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) load(8'hA0 + 8'(i));
        drain(100);
        check("t4_count", 32'(log_d.size()), 32'd4);
        for (int i = 0; i < log_d.size(); i++) begin
            check("t4_data", 32'(log_d[i]), 32'(8'hA0 + 8'(i)));
        end

`ifdef FIFO_RD_STREAM_LAST_EN
        // Framing with length 4 and random ready.
        do_reset();
        clear_log();
        pkt_len    = 16'd4;
        rand_ready = 1'b1;
        tx_ready   = 1'b1;
        for (int i = 0; i < 12; i++) load(8'h60 + 8'(i));
        drain(500);
        rand_ready = 1'b0;
        check("t5_count", 32'(log_l.size()), 32'd12);
        for (int i = 0; i < log_l.size(); i++) begin
            check("t5_last", 32'(log_l[i]), 32'(((i + 1) % 4) == 0));
        end

        // Length 0 (unframed), then 3.
        do_reset();
        clear_log();
        pkt_len  = 16'd0;
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) load(8'h70 + 8'(i));
        drain(100);
        check("t6_count0", 32'(log_l.size()), 32'd5);
        for (int i = 0; i < log_l.size(); i++) begin
            check("t6_last0", 32'(log_l[i]), 32'd0);
        end
        clear_log();
        pkt_len = 16'd3;
        for (int i = 0; i < 9; i++) load(8'h80 + 8'(i));
        drain(100);
        check("t6_count3", 32'(log_l.size()), 32'd9);
        for (int i = 0; i < log_l.size(); i++) begin
            check("t6_last3", 32'(log_l[i]), 32'(((i + 1) % 3) == 0));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
